// File: rtl/qea_pkg.sv
// Shared types and constants for the QEA host-side job sequencer.
// Covers the FSM encoding, bus widths, the |0...0> amplitude and the row-count helper.
package qea_pkg;

    localparam int unsigned PE_NUM                  = 4;
    localparam int unsigned STATE_DATA_WIDTH        = 64;
    localparam int unsigned STATE_ADDR_WIDTH        = 16;
    localparam int unsigned GATE_CONTEXT_DATA_WIDTH = 64;
    localparam int unsigned GATE_CONTEXT_ADDR_WIDTH = 16;
    localparam int unsigned MAX_QBIT_WIDTH          = 6;
    localparam int unsigned CYC_WIDTH               = 32;

    localparam int unsigned ROW_WIDTH     = PE_NUM * STATE_DATA_WIDTH;
    // One extra bit so a full 2^STATE_ADDR_WIDTH row count is representable
    localparam int unsigned ROW_CNT_WIDTH = STATE_ADDR_WIDTH + 1;

    localparam logic [31:0] ONE_Q2_30 = 32'h4000_0000;
    localparam logic [ROW_WIDTH-1:0] INIT_ROW0 = {ONE_Q2_30, {(ROW_WIDTH - 32){1'b0}}};

    localparam logic [MAX_QBIT_WIDTH-1:0] QBIT_MIN = MAX_QBIT_WIDTH'(2);
    localparam logic [MAX_QBIT_WIDTH-1:0] QBIT_MAX = MAX_QBIT_WIDTH'(STATE_ADDR_WIDTH + 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_LOAD_CTX,
        S_INIT_STATE,
        S_START,
        S_RUN,
        S_READ,
        S_DONE
    } job_state_e;

    // Number of state RAM rows holding 2^n amplitudes, PE_NUM per row
    function automatic logic [ROW_CNT_WIDTH-1:0] rows_for_qbits(input logic [MAX_QBIT_WIDTH-1:0] n);
        return ROW_CNT_WIDTH'(1) << (n - MAX_QBIT_WIDTH'(2));
    endfunction

endpackage

// File: rtl/qea_job_ctrl_if.sv
// Host-facing bundle of qea_job_ctrl: job request, context stream, state readout and status.
interface qea_job_ctrl_if;
    import qea_pkg::*;

    logic                               i_job_start;
    logic [MAX_QBIT_WIDTH-1:0]          i_qbit_num;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0] i_ins_num;
    logic                               i_ctx_valid;
    logic                               o_ctx_ready;
    logic [GATE_CONTEXT_DATA_WIDTH-1:0] i_ctx_data;
    logic                               o_out_valid;
    logic                               i_out_ready;
    logic [ROW_WIDTH-1:0]               o_out_data;
    logic                               o_busy;
    logic                               o_done;
    logic                               o_err;
    logic [CYC_WIDTH-1:0]               o_cycles;

    modport master (
        output i_job_start, i_qbit_num, i_ins_num, i_ctx_valid, i_ctx_data, i_out_ready,
        input  o_ctx_ready, o_out_valid, o_out_data, o_busy, o_done, o_err, o_cycles
    );

    modport slave (
        input  i_job_start, i_qbit_num, i_ins_num, i_ctx_valid, i_ctx_data, i_out_ready,
        output o_ctx_ready, o_out_valid, o_out_data, o_busy, o_done, o_err, o_cycles
    );

endinterface

// File: rtl/qea_out_skid.sv
// Two-entry valid/ready FIFO with a registered head; the producer must never push when full.
module qea_out_skid
    import qea_pkg::*;
#(
    parameter int unsigned WIDTH = ROW_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count_c
);

    logic             tail_valid;
    logic [WIDTH-1:0] tail_data;
    logic             pop_c;

    assign pop_c   = out_valid & out_ready;
    assign count_c = 2'(out_valid) + 2'(tail_valid);

    // Head register feeds the port directly, so data holds while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            tail_valid <= 1'b0;
            tail_data  <= '0;
        end else if (pop_c) begin
            if (tail_valid) begin
                out_data   <= tail_data;
                tail_valid <= in_valid;
                if (in_valid) tail_data <= in_data;
            end else begin
                out_valid <= in_valid;
                if (in_valid) out_data <= in_data;
            end
        end else if (in_valid) begin
            if (!out_valid) begin
                out_valid <= 1'b1;
                out_data  <= in_data;
            end else begin
                tail_valid <= 1'b1;
                tail_data  <= in_data;
            end
        end
    end

endmodule

// File: rtl/qea_job_ctrl.sv
// Job sequencer in front of the QEA core: loads context, seeds |0...0>, starts and times the
// core, then streams the final state vector back to the host.
module qea_job_ctrl
    import qea_pkg::*;
(
    input  logic                               clk,
    input  logic                               rst,
    qea_job_ctrl_if.slave                      host,
    output logic                               o_qea_start,
    output logic [MAX_QBIT_WIDTH-1:0]          o_qea_qbit_num,
    output logic                               o_ctx_en,
    output logic                               o_ctx_wea,
    output logic [GATE_CONTEXT_ADDR_WIDTH-1:0] o_ctx_addr,
    output logic [GATE_CONTEXT_DATA_WIDTH-1:0] o_ctx_data,
    output logic                               o_state_ena,
    output logic                               o_state_wea,
    output logic [STATE_ADDR_WIDTH-1:0]        o_state_addra,
    output logic [ROW_WIDTH-1:0]               o_state_dina,
    input  logic                               i_qea_complete,
    input  logic [ROW_WIDTH-1:0]               i_qea_state_dout
);

    job_state_e                         state;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0] ins_q;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0] ctx_cnt;
    logic [ROW_CNT_WIDTH-1:0]           rows_q;
    logic [ROW_CNT_WIDTH-1:0]           row_cnt;
    logic [ROW_CNT_WIDTH-1:0]           pop_cnt;
    logic [CYC_WIDTH-1:0]               cyc_cnt;
    logic [CYC_WIDTH-1:0]               cycles_q;
    logic                               busy_q;
    logic                               done_q;
    logic                               err_q;
    logic                               ctx_ready_q;
    logic                               rd_pend1;
    logic                               rd_pend2;

    logic                               skid_valid;
    logic [ROW_WIDTH-1:0]               skid_data;
    logic [1:0]                         skid_count_c;
    logic                               out_pop_c;
    logic                               ctx_acc_c;
    logic                               qbit_bad_c;
    logic [2:0]                         pending_c;
    logic                               rd_issue_c;

    assign host.o_ctx_ready = ctx_ready_q;
    assign host.o_out_valid = skid_valid;
    assign host.o_out_data  = skid_data;
    assign host.o_busy      = busy_q;
    assign host.o_done      = done_q;
    assign host.o_err       = err_q;
    assign host.o_cycles    = cycles_q;

    assign out_pop_c  = skid_valid & host.i_out_ready;
    assign ctx_acc_c  = ctx_ready_q & host.i_ctx_valid;
    assign qbit_bad_c = (o_qea_qbit_num < QBIT_MIN) || (o_qea_qbit_num > QBIT_MAX);

    // Rows that will occupy the skid once everything already requested has landed
    assign pending_c  = 3'(skid_count_c) + 3'(rd_pend1) + 3'(rd_pend2) - 3'(out_pop_c);
    assign rd_issue_c = (state == S_READ) && (row_cnt < rows_q) && (pending_c < 3'd2);

    qea_out_skid #(.WIDTH(ROW_WIDTH)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rd_pend2),
        .in_data   (i_qea_state_dout),
        .out_valid (skid_valid),
        .out_ready (host.i_out_ready),
        .out_data  (skid_data),
        .count_c   (skid_count_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            ins_q          <= '0;
            ctx_cnt        <= '0;
            rows_q         <= '0;
            row_cnt        <= '0;
            pop_cnt        <= '0;
            cyc_cnt        <= '0;
            cycles_q       <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            ctx_ready_q    <= 1'b0;
            rd_pend1       <= 1'b0;
            rd_pend2       <= 1'b0;
            o_qea_start    <= 1'b0;
            o_qea_qbit_num <= '0;
            o_ctx_en       <= 1'b0;
            o_ctx_wea      <= 1'b0;
            o_ctx_addr     <= '0;
            o_ctx_data     <= '0;
            o_state_ena    <= 1'b0;
            o_state_wea    <= 1'b0;
            o_state_addra  <= '0;
            o_state_dina   <= '0;
        end else begin
            o_ctx_en    <= 1'b0;
            o_ctx_wea   <= 1'b0;
            o_state_ena <= 1'b0;
            o_state_wea <= 1'b0;
            o_qea_start <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            // Read data appears on i_qea_state_dout the cycle after the address is driven
            rd_pend1    <= rd_issue_c;
            rd_pend2    <= rd_pend1;

            case (state)
                S_IDLE: begin
                    if (host.i_job_start) begin
                        o_qea_qbit_num <= host.i_qbit_num;
                        ins_q          <= host.i_ins_num;
                        busy_q         <= 1'b1;
                        state          <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    rows_q  <= rows_for_qbits(o_qea_qbit_num);
                    ctx_cnt <= '0;
                    row_cnt <= '0;
                    if (qbit_bad_c) begin
                        done_q <= 1'b1;
                        err_q  <= 1'b1;
                        state  <= S_DONE;
                    end else if (ins_q == '0) begin
                        state <= S_INIT_STATE;
                    end else begin
                        ctx_ready_q <= 1'b1;
                        state       <= S_LOAD_CTX;
                    end
                end
                S_LOAD_CTX: begin
                    if (ctx_acc_c) begin
                        o_ctx_en   <= 1'b1;
                        o_ctx_wea  <= 1'b1;
                        o_ctx_addr <= ctx_cnt;
                        o_ctx_data <= host.i_ctx_data;
                        ctx_cnt    <= ctx_cnt + GATE_CONTEXT_ADDR_WIDTH'(1);
                        if (ctx_cnt == ins_q - GATE_CONTEXT_ADDR_WIDTH'(1)) begin
                            ctx_ready_q <= 1'b0;
                            state       <= S_INIT_STATE;
                        end
                    end
                end
                S_INIT_STATE: begin
                    o_state_ena   <= 1'b1;
                    o_state_wea   <= 1'b1;
                    o_state_addra <= STATE_ADDR_WIDTH'(row_cnt);
                    o_state_dina  <= (row_cnt == '0) ? INIT_ROW0 : '0;
                    row_cnt       <= row_cnt + ROW_CNT_WIDTH'(1);
                    if (row_cnt == rows_q - ROW_CNT_WIDTH'(1)) begin
                        o_qea_start <= 1'b1;
                        state       <= S_START;
                    end
                end
                S_START: begin
                    cyc_cnt <= CYC_WIDTH'(1);
                    row_cnt <= '0;
                    pop_cnt <= '0;
                    state   <= S_RUN;
                end
                S_RUN: begin
                    // A stale complete level from the previous job is masked for two cycles
                    if ((cyc_cnt >= CYC_WIDTH'(3)) && i_qea_complete) begin
                        cycles_q <= cyc_cnt;
                        state    <= S_READ;
                    end else if (cyc_cnt != '1) begin
                        cyc_cnt <= cyc_cnt + CYC_WIDTH'(1);
                    end
                end
                S_READ: begin
                    if (rd_issue_c) begin
                        o_state_ena   <= 1'b1;
                        o_state_addra <= STATE_ADDR_WIDTH'(row_cnt);
                        row_cnt       <= row_cnt + ROW_CNT_WIDTH'(1);
                    end
                    if (out_pop_c) begin
                        pop_cnt <= pop_cnt + ROW_CNT_WIDTH'(1);
                        if (pop_cnt == rows_q - ROW_CNT_WIDTH'(1)) begin
                            done_q <= 1'b1;
                            state  <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qea_job_ctrl.sv
// Directed bench for qea_job_ctrl with a latency-programmable core model and a patterned state RAM.
module tb_qea_job_ctrl;
    import qea_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    qea_job_ctrl_if bus();

    logic                               o_qea_start;
    logic [MAX_QBIT_WIDTH-1:0]          o_qea_qbit_num;
    logic                               o_ctx_en;
    logic                               o_ctx_wea;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0] o_ctx_addr;
    logic [GATE_CONTEXT_DATA_WIDTH-1:0] o_ctx_data;
    logic                               o_state_ena;
    logic                               o_state_wea;
    logic [STATE_ADDR_WIDTH-1:0]        o_state_addra;
    logic [ROW_WIDTH-1:0]               o_state_dina;
    logic                               qea_complete;
    logic [ROW_WIDTH-1:0]               ram_dout = '0;

    qea_job_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .host             (bus),
        .o_qea_start      (o_qea_start),
        .o_qea_qbit_num   (o_qea_qbit_num),
        .o_ctx_en         (o_ctx_en),
        .o_ctx_wea        (o_ctx_wea),
        .o_ctx_addr       (o_ctx_addr),
        .o_ctx_data       (o_ctx_data),
        .o_state_ena      (o_state_ena),
        .o_state_wea      (o_state_wea),
        .o_state_addra    (o_state_addra),
        .o_state_dina     (o_state_dina),
        .i_qea_complete   (qea_complete),
        .i_qea_state_dout (ram_dout)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ctxw(input int k);
        return {32'hC0FFEE00 + 32'(k), 32'(k) ^ 32'h5555AAAA};
    endfunction

    function automatic logic [255:0] pat(input logic [15:0] a);
        return {16'hBEEF, a, 32'h0A0B0C0D, 16'h5A5A, ~a, 32'h11223344,
                64'h0123456789ABCDEF ^ {48'h0, a}, 64'hFEDC000000000000 | {48'h0, a}};
    endfunction

    // Core model: complete rises core_lat cycles after the start pulse and stays high
    int unsigned core_lat = 1000;
    int unsigned core_cnt;
    logic        hold_complete = 1'b0;
    always @(posedge clk or posedge rst) begin
        if (rst) core_cnt <= 0;
        else if (o_qea_start) core_cnt <= 1;
        else if (core_cnt != 0 && core_cnt < core_lat) core_cnt <= core_cnt + 1;
    end
    assign qea_complete = hold_complete | (core_cnt != 0 && core_cnt >= core_lat);

    always @(posedge clk) begin
        if (o_state_ena && !o_state_wea) ram_dout <= pat(o_state_addra);
    end

    bit rnd_ready = 1'b0;
    initial begin
        bus.i_out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.i_out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    logic [15:0]  ctx_addr_q[$];
    logic [63:0]  ctx_data_q[$];
    logic [15:0]  init_addr_q[$];
    logic [255:0] init_data_q[$];
    logic [255:0] out_q[$];
    int           start_cnt = 0;
    int           done_cnt = 0;
    int           ctx_bad = 0;
    bit           prev_stall = 1'b0;
    logic [255:0] prev_data = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (o_ctx_en) begin
                ctx_addr_q.push_back(o_ctx_addr);
                ctx_data_q.push_back(o_ctx_data);
                if (!o_ctx_wea) ctx_bad++;
            end
            if (o_state_ena && o_state_wea) begin
                init_addr_q.push_back(o_state_addra);
                init_data_q.push_back(o_state_dina);
            end
            if (o_qea_start) start_cnt++;
            if (bus.o_done) done_cnt++;
            if (bus.o_out_valid && bus.i_out_ready) out_q.push_back(bus.o_out_data);
            if (prev_stall) begin
                chk("stall_valid", bus.o_out_valid, 1);
                chk("stall_data", bus.o_out_data, prev_data);
            end
            prev_stall = bus.o_out_valid && !bus.i_out_ready;
            prev_data  = bus.o_out_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic clear_logs();
        ctx_addr_q.delete();
        ctx_data_q.delete();
        init_addr_q.delete();
        init_data_q.delete();
        out_q.delete();
        start_cnt = 0;
        done_cnt  = 0;
        ctx_bad   = 0;
    endtask

    task automatic pulse_start(input int qb, input int ins);
        @(posedge clk);
        #1;
        bus.i_qbit_num  = MAX_QBIT_WIDTH'(qb);
        bus.i_ins_num   = GATE_CONTEXT_ADDR_WIDTH'(ins);
        bus.i_job_start = 1'b1;
        @(posedge clk);
        #1;
        bus.i_job_start = 1'b0;
    endtask

    task automatic send_ctx(input int n, input bit gappy);
        int k = 0;
        int g = 0;
        bit acc;
        while (k < n && g < 4000) begin
            bus.i_ctx_valid = gappy ? ((g % 2) == 0) : 1'b1;
            bus.i_ctx_data  = ctxw(k);
            @(negedge clk);
            acc = bus.i_ctx_valid && bus.o_ctx_ready;
            @(posedge clk);
            #1;
            if (acc) k++;
            g++;
        end
        bus.i_ctx_valid = 1'b0;
        chk("ctx_sent", k, n);
    endtask

    task automatic run_job(input int qb, input int ins, input int lat, input bit gappy,
                           input bit rnd, input int exp_cyc, input string tag);
        int  rows = 1 << (qb - 2);
        int  t = 0;
        int  m;
        bit  got_done = 1'b0;
        bit  got_err = 1'b0;
        logic [255:0] exp_row0 = 256'h4000_0000 << 224;
        clear_logs();
        core_lat  = lat;
        rnd_ready = rnd;
        pulse_start(qb, ins);
        if (ins > 0) send_ctx(ins, gappy);
        while (!got_done && t < 20000) begin
            @(negedge clk);
            t++;
            if (bus.o_done) begin
                got_done = 1'b1;
                got_err  = bus.o_err;
            end
        end
        chk({tag, "_done"}, got_done, 1);
        chk({tag, "_err"}, got_err, 0);
        chk({tag, "_cycles"}, bus.o_cycles, exp_cyc);
        chk({tag, "_qbit"}, o_qea_qbit_num, qb);
        chk({tag, "_starts"}, start_cnt, 1);
        chk({tag, "_ctx_n"}, ctx_addr_q.size(), ins);
        m = ctx_bad;
        foreach (ctx_addr_q[i]) if (ctx_addr_q[i] !== 16'(i) || ctx_data_q[i] !== ctxw(i)) m++;
        chk({tag, "_ctx_order"}, m, 0);
        chk({tag, "_init_n"}, init_addr_q.size(), rows);
        m = 0;
        foreach (init_addr_q[i])
            if (init_addr_q[i] !== 16'(i) || init_data_q[i] !== ((i == 0) ? exp_row0 : 256'h0)) m++;
        chk({tag, "_init_data"}, m, 0);
        chk({tag, "_out_n"}, out_q.size(), rows);
        m = 0;
        foreach (out_q[i]) if (out_q[i] !== pat(16'(i))) m++;
        chk({tag, "_out_order"}, m, 0);
        @(posedge clk);
        #1;
        chk({tag, "_idle_busy"}, bus.o_busy, 0);
        rnd_ready = 1'b0;
    endtask

    task automatic reject_job(input int qb, input int prev_cyc, input string tag);
        bit got_done = 1'b0;
        bit got_err = 1'b0;
        clear_logs();
        bus.i_ctx_valid = 1'b1;
        bus.i_ctx_data  = ctxw(7);
        pulse_start(qb, 5);
        for (int c = 0; c < 3 && !got_done; c++) begin
            @(negedge clk);
            if (bus.o_done) begin
                got_done = 1'b1;
                got_err  = bus.o_err;
            end
        end
        repeat (3) @(posedge clk);
        #1;
        bus.i_ctx_valid = 1'b0;
        chk({tag, "_done"}, got_done, 1);
        chk({tag, "_err"}, got_err, 1);
        chk({tag, "_no_ctx"}, ctx_addr_q.size(), 0);
        chk({tag, "_no_init"}, init_addr_q.size(), 0);
        chk({tag, "_no_start"}, start_cnt, 0);
        chk({tag, "_cycles_kept"}, bus.o_cycles, prev_cyc);
        chk({tag, "_busy"}, bus.o_busy, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        bus.i_job_start = 1'b0;
        bus.i_qbit_num  = '0;
        bus.i_ins_num   = '0;
        bus.i_ctx_valid = 1'b0;
        bus.i_ctx_data  = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_flags", {bus.o_busy, bus.o_done, bus.o_err, bus.o_ctx_ready, bus.o_out_valid,
                          o_qea_start, o_ctx_en, o_state_ena}, 8'h00);
        chk("rst_cycles", bus.o_cycles, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        run_job(6, 195, 500, 1'b0, 1'b0, 500, "job1");
        reject_job(1, 500, "rej_q1");
        reject_job(19, 500, "rej_q19");

        hold_complete = 1'b1;
        run_job(2, 0, 1000, 1'b0, 1'b0, 3, "hold");
        hold_complete = 1'b0;

        run_job(6, 10, 40, 1'b1, 1'b1, 40, "gappy");

        // Abort a job mid-RUN with reset
        clear_logs();
        core_lat = 1000;
        pulse_start(3, 2);
        send_ctx(2, 1'b0);
        t = 0;
        while (start_cnt == 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("abort_started", start_cnt, 1);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_flags", {bus.o_busy, bus.o_done, bus.o_err, bus.o_ctx_ready, bus.o_out_valid,
                            o_qea_start, o_ctx_en, o_state_ena}, 8'h00);
        chk("abort_cycles", bus.o_cycles, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_no_done", done_cnt, 0);
        repeat (2) @(posedge clk);
        #1;

        run_job(4, 3, 20, 1'b0, 1'b1, 20, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
